// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: op one-hot bit positions and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package div_unit_pkg;

    // Bit positions inside the one-hot divide op field
    localparam int OP_DIV  = 0;
    localparam int OP_DIVU = 1;
    localparam int OP_REM  = 2;
    localparam int OP_REMU = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage, the divider and the writeback consumer.
// Latency: n/a (wiring only).
// Backpressure: E_div_ready_o gates requests, W_ready_i gates result handoff.
interface div_unit_if #(
    parameter int XLEN = 32
) ();

    logic            E_div_valid_i;
    logic [3:0]      E_div_op_i;
    logic [XLEN-1:0] E_div_op1_i;
    logic [XLEN-1:0] E_div_op2_i;
    logic            E_div_ready_o;
    logic            D_flush_i;
    logic            DIV_valid_o;
    logic [XLEN-1:0] DIV_result_o;
    logic            W_ready_i;

    // Pipeline side: issues requests, flushes, consumes results
    modport master (
        output E_div_valid_i, E_div_op_i, E_div_op1_i, E_div_op2_i, D_flush_i, W_ready_i,
        input  E_div_ready_o, DIV_valid_o, DIV_result_o
    );

    // Divider side
    modport slave (
        input  E_div_valid_i, E_div_op_i, E_div_op1_i, E_div_op2_i, D_flush_i, W_ready_i,
        output E_div_ready_o, DIV_valid_o, DIV_result_o
    );

endinterface

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
// Latency: combinational.
// Backpressure: none.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] dvd_in,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] dvd_out,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Shift remainder:dividend left, trial-subtract, restore on a negative result.
    // The remainder is always below the divisor, so XLEN+1 bits never overflow.
    always_comb begin
        shifted = {rem_in, dvd_in[XLEN-1]};
        diff    = shifted - {1'b0, dvs};
        q_bit   = ~diff[XLEN];
        rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        dvd_out = {dvd_in[XLEN-2:0], q_bit};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative RISC-V style divider (div/divu/rem/remu) with a single outstanding request.
// Latency: XLEN cycles accept->valid; divide-by-zero and signed overflow in 1 cycle.
// Backpressure: ready only in IDLE; result held in DONE until W_ready_i; flush drops everything.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic    clk,
    input  logic    rst_n,
    div_unit_if.slave bus
);

    localparam int CNT_W = $clog2(XLEN);

    state_t          state, state_nxt;
    logic [XLEN-1:0] rem_q, dvd_q, dvs_q;
    logic [3:0]      op_q;
    logic            q_neg_q, r_neg_q;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, is_signed_in, div0, ovf;
    logic [XLEN-1:0] op1, op2, abs1, abs2;
    logic [XLEN-1:0] step_rem, step_dvd;
    logic            step_q;
    logic [XLEN-1:0] quo, rmd;
    logic            ready, valid;

    assign op1 = bus.E_div_op1_i;
    assign op2 = bus.E_div_op2_i;

    // Request decode: operand magnitudes and the two single-cycle special cases
    always_comb begin
        is_signed_in = bus.E_div_op_i[OP_DIV] | bus.E_div_op_i[OP_REM];
        abs1         = op1[XLEN-1] ? -op1 : op1;
        abs2         = op2[XLEN-1] ? -op2 : op2;
        div0         = (op2 == '0);
        ovf          = is_signed_in && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
        accept       = (state == S_IDLE) && bus.E_div_valid_i && !bus.D_flush_i;
    end

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .dvd_in  (dvd_q),
        .dvs     (dvs_q),
        .rem_out (step_rem),
        .dvd_out (step_dvd),
        .q_bit   (step_q)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs; flush overrides every other transition
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        valid     = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (accept) state_nxt = (div0 || ovf) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                if (cnt_q == CNT_W'(XLEN-1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                valid = 1'b1;
                if (bus.W_ready_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (bus.D_flush_i) state_nxt = S_IDLE;
    end

    // Datapath: load on accept (special cases preload the final answer), iterate in CALC.
    // After XLEN steps dvd_q holds the quotient magnitude and rem_q the remainder magnitude.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            op_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            op_q  <= bus.E_div_op_i;
            cnt_q <= '0;
            dvs_q <= is_signed_in ? abs2 : op2;
            if (div0) begin
                dvd_q   <= '1;
                rem_q   <= op1;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
            end else if (ovf) begin
                dvd_q   <= op1;
                rem_q   <= '0;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
            end else begin
                dvd_q   <= is_signed_in ? abs1 : op1;
                rem_q   <= '0;
                q_neg_q <= is_signed_in & (op1[XLEN-1] ^ op2[XLEN-1]);
                r_neg_q <= is_signed_in & op1[XLEN-1];
            end
        end else if (state == S_CALC && !bus.D_flush_i) begin
            rem_q <= step_rem;
            dvd_q <= step_dvd;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Sign fix-up and result select; output forced to zero outside DONE
    always_comb begin
        quo = (q_neg_q && op_q[OP_DIV]) ? -dvd_q : dvd_q;
        rmd = (r_neg_q && op_q[OP_REM]) ? -rem_q : rem_q;
        bus.DIV_result_o  = '0;
        if (state == S_DONE)
            bus.DIV_result_o = (op_q[OP_REM] || op_q[OP_REMU]) ? rmd : quo;
        bus.DIV_valid_o   = valid;
        bus.E_div_ready_o = ready;
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Latency: checks 32-cycle normal path and 1-cycle special cases.
// Backpressure: exercises W_ready_i stall, flush and async reset.
module tb_div_unit;

    localparam logic [3:0] DIV  = 4'b0001;
    localparam logic [3:0] DIVU = 4'b0010;
    localparam logic [3:0] REM  = 4'b0100;
    localparam logic [3:0] REMU = 4'b1000;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request from #1 after an edge; it is accepted at the next edge.
    // Inputs are scrambled right after so the unit must rely on latched values.
    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.E_div_valid_i = 1'b1;
        bus.E_div_op_i    = op;
        bus.E_div_op1_i   = a;
        bus.E_div_op2_i   = b;
        @(posedge clk); #1;
        bus.E_div_valid_i = 1'b0;
        bus.E_div_op_i    = REMU;
        bus.E_div_op1_i   = $urandom;
        bus.E_div_op2_i   = $urandom;
    endtask

    // Edges after the accept edge until valid is seen; -1 when it never comes
    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.DIV_valid_o !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.DIV_valid_o !== 1'b1) lat = -1;
    endtask

    // Full transaction with W_ready_i high: returns latency and result, then hands off
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res);
        start_op(op, a, b);
        wait_valid(lat);
        res = bus.DIV_result_o;
        if (lat >= 0) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.DIV_valid_o !== 1'b0 || bus.DIV_result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b result=%h required valid=0 result=0",
                     bus.DIV_valid_o, bus.DIV_result_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.E_div_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", bus.E_div_ready_o);
        end
        checks++;
        if (bus.DIV_valid_o !== 1'b0 || bus.DIV_result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_release valid=%b result=%h required 0/0",
                     bus.DIV_valid_o, bus.DIV_result_o);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        logic [31:0] res;
        run_op(DIVU, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat != 32) begin errors++; $display("FAIL divu_latency got %0d required 32", lat); end
        checks++;
        if (res !== 32'd14) begin errors++; $display("FAIL divu_100_7 got %h required %h", res, 32'd14); end
        checks++;
        if (bus.E_div_ready_o !== 1'b1 || bus.DIV_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_handoff ready=%b valid=%b required 1/0", bus.E_div_ready_o, bus.DIV_valid_o);
        end
        run_op(REMU, 32'd100, 32'd7, lat, res);
        checks++;
        if (lat != 32) begin errors++; $display("FAIL remu_latency got %0d required 32", lat); end
        checks++;
        if (res !== 32'd2) begin errors++; $display("FAIL remu_100_7 got %h required %h", res, 32'd2); end
        run_op(DIVU, 32'hFFFFFFF9, 32'd2, lat, res);
        checks++;
        if (res !== 32'h7FFFFFFC) begin errors++; $display("FAIL divu_big got %h required 7ffffffc", res); end
    endtask

    task automatic test_signed();
        int lat;
        logic [31:0] res;
        run_op(DIV, 32'hFFFFFFF9, 32'd2, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFD || lat != 32) begin
            errors++; $display("FAIL div_m7_2 got %h lat %0d required fffffffd lat 32", res, lat);
        end
        run_op(REM, 32'hFFFFFFF9, 32'd2, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFF) begin errors++; $display("FAIL rem_m7_2 got %h required ffffffff", res); end
        run_op(DIV, 32'd7, 32'hFFFFFFFE, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_7_m2 got %h required fffffffd", res); end
        run_op(REM, 32'd7, 32'hFFFFFFFE, lat, res);
        checks++;
        if (res !== 32'd1) begin errors++; $display("FAIL rem_7_m2 got %h required 00000001", res); end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [31:0] res;
        run_op(DIV, 32'd5, 32'd0, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFF || lat != 0) begin
            errors++; $display("FAIL div_by_zero got %h lat %0d required ffffffff lat 0", res, lat);
        end
        run_op(REMU, 32'd5, 32'd0, lat, res);
        checks++;
        if (res !== 32'd5 || lat != 0) begin
            errors++; $display("FAIL remu_by_zero got %h lat %0d required 00000005 lat 0", res, lat);
        end
        run_op(REM, 32'hFFFFFFFB, 32'd0, lat, res);
        checks++;
        if (res !== 32'hFFFFFFFB || lat != 0) begin
            errors++; $display("FAIL rem_neg_by_zero got %h lat %0d required fffffffb lat 0", res, lat);
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] res;
        run_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== 32'h80000000 || lat != 0) begin
            errors++; $display("FAIL div_overflow got %h lat %0d required 80000000 lat 0", res, lat);
        end
        run_op(REM, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== 32'h0 || lat != 0) begin
            errors++; $display("FAIL rem_overflow got %h lat %0d required 0 lat 0", res, lat);
        end
        run_op(DIVU, 32'h80000000, 32'hFFFFFFFF, lat, res);
        checks++;
        if (res !== 32'h0 || lat != 32) begin
            errors++; $display("FAIL divu_no_overflow got %h lat %0d required 0 lat 32", res, lat);
        end
    endtask

    task automatic test_flush();
        int lat;
        int seen;
        logic [31:0] res;
        start_op(DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.E_div_ready_o !== 1'b0 || bus.DIV_result_o !== 32'h0) begin
            errors++;
            $display("FAIL calc_outputs ready=%b result=%h required 0/0", bus.E_div_ready_o, bus.DIV_result_o);
        end
        bus.D_flush_i = 1'b1;
        @(posedge clk); #1;
        bus.D_flush_i = 1'b0;
        checks++;
        if (bus.E_div_ready_o !== 1'b1 || bus.DIV_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle ready=%b valid=%b required 1/0", bus.E_div_ready_o, bus.DIV_valid_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DIV_valid_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_valid got %0d valid cycles required 0", seen); end
        // Flush wins over a simultaneous request
        bus.D_flush_i = 1'b1;
        start_op(DIVU, 32'd50, 32'd5);
        bus.D_flush_i = 1'b0;
        checks++;
        if (bus.E_div_ready_o !== 1'b1) begin
            errors++; $display("FAIL flush_beats_accept ready=%b required 1", bus.E_div_ready_o);
        end
        run_op(DIVU, 32'd9, 32'd3, lat, res);
        checks++;
        if (res !== 32'd3 || lat != 32) begin
            errors++; $display("FAIL after_flush got %h lat %0d required 00000003 lat 32", res, lat);
        end
    endtask

    task automatic test_hold();
        int lat;
        int seen;
        bus.W_ready_i = 1'b0;
        start_op(DIVU, 32'd100, 32'd7);
        wait_valid(lat);
        checks++;
        if (lat != 32) begin errors++; $display("FAIL hold_latency got %0d required 32", lat); end
        // A request presented while DONE must be ignored
        bus.E_div_valid_i = 1'b1;
        bus.E_div_op_i    = DIVU;
        bus.E_div_op1_i   = 32'd77;
        bus.E_div_op2_i   = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.DIV_valid_o !== 1'b1 || bus.DIV_result_o !== 32'd14 || bus.E_div_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d valid=%b result=%h ready=%b required 1/0000000e/0",
                         i, bus.DIV_valid_o, bus.DIV_result_o, bus.E_div_ready_o);
            end
        end
        bus.W_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.E_div_valid_i = 1'b0;
        checks++;
        if (bus.DIV_valid_o !== 1'b0 || bus.E_div_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL hold_release valid=%b ready=%b required 0/1", bus.DIV_valid_o, bus.E_div_ready_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DIV_valid_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL done_no_accept got %0d valid cycles required 0", seen); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        logic [31:0] res;
        start_op(DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.DIV_valid_o !== 1'b0 || bus.DIV_result_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs valid=%b result=%h required 0/0", bus.DIV_valid_o, bus.DIV_result_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.E_div_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready got %b required 1", bus.E_div_ready_o);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.DIV_valid_o === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_no_valid got %0d valid cycles required 0", seen); end
        run_op(REMU, 32'd23, 32'd5, lat, res);
        checks++;
        if (res !== 32'd3) begin errors++; $display("FAIL after_reset got %h required 00000003", res); end
    endtask

    initial begin
        checks            = 0;
        errors            = 0;
        rst_n             = 1'b0;
        bus.E_div_valid_i = 1'b0;
        bus.E_div_op_i    = 4'b0000;
        bus.E_div_op1_i   = 32'h0;
        bus.E_div_op2_i   = 32'h0;
        bus.D_flush_i     = 1'b0;
        bus.W_ready_i     = 1'b1;

        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_flush();
        test_hold();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter XLEN, default 32, operand and result width.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 E_div_valid_i  input  1  execute stage presents a divide request.
REQ-005 E_div_op_i  input  4  one-hot op: bit0 div, bit1 divu, bit2 rem, bit3 remu.
REQ-006 E_div_op1_i  input  XLEN  dividend.
REQ-007 E_div_op2_i  input  XLEN  divisor.
REQ-008 E_div_ready_o  output  1  unit can accept a request.
REQ-009 D_flush_i  input  1  pipeline flush; kills any in-flight request.
REQ-010 DIV_valid_o  output  1  result available.
REQ-011 DIV_result_o  output  XLEN  quotient or remainder per latched op.
REQ-012 W_ready_i  input  1  consumer accepts result.

Function
REQ-013 FSM states IDLE, CALC, DONE; E_div_ready_o=1 only in IDLE.
REQ-014 Accept: IDLE & E_div_valid_i & ~D_flush_i at edge T; latch op, operand magnitudes, quotient sign (op1 MSB ^ op2 MSB), remainder sign (op1 MSB).
REQ-015 Signed ops (div, rem) use absolute values; unsigned ops (divu, remu) use raw operands.
REQ-016 Fast path at T, straight to DONE: divisor==0 -> div/divu 0xFFFFFFFF, rem/remu = op1; signed overflow (op1=0x80000000, op2=0xFFFFFFFF) -> div 0x80000000, rem 0.
REQ-017 Normal path: T -> CALC, iteration counter 0; edges T+1..T+32 each perform one radix-2 restoring step (shift remainder:dividend left 1, trial subtract divisor, keep if non-negative, set quotient bit).
REQ-018 At edge T+32 (counter==XLEN-1) -> DONE; DIV_valid_o high in the cycle after edge T+32; fast path, cycle after edge T.
REQ-019 Sign fix-up: negate quotient when quotient sign set and op is div; negate remainder when remainder sign set and op is rem.
REQ-020 DIV_result_o = quotient for div/divu, remainder for rem/remu; stable whole DONE; 0 outside DONE.
REQ-021 DONE & W_ready_i -> IDLE next edge; W_ready_i low holds DONE and result indefinitely.
REQ-022 No new request accepted in the DONE cycle; E_div_ready_o returns high in the cycle after handoff.
REQ-023 D_flush_i in any state -> IDLE next edge, DIV_valid_o low, no result delivered; flush beats a simultaneous accept or handoff.
REQ-024 Inputs ignored outside the accept cycle; operands need not stay stable during CALC.

Reset
REQ-025 rst_n low asynchronously forces IDLE, counter 0, datapath registers 0, DIV_valid_o 0, DIV_result_o 0, E_div_ready_o 1 after release.
REQ-026 Reset mid-CALC or mid-DONE discards the operation; no output glitch to valid after release.

Structure
REQ-027 Op one-hot bit indices (div/divu/rem/remu) and FSM state encoding live in the shared define header beside the existing ALU op defines.
REQ-028 One combinational sub-module div_step: one restoring iteration (partial remainder, dividend, divisor in; next remainder, dividend, quotient bit out).
REQ-029 Total RTL, FSM plus datapath, 120-400 lines; no `/` or `%` operators.

Verification
REQ-030 divu 100/7 -> valid 32 cycles after accept, result 14; remu same operands -> 2.
REQ-031 div 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); rem -> 0xFFFFFFFF (-1).
REQ-032 div 5/0 -> 0xFFFFFFFF; remu 5/0 -> 5; both valid cycle after accept.
REQ-033 div 0x80000000 / 0xFFFFFFFF -> 0x80000000; rem -> 0; fast path.
REQ-034 Flush at CALC iteration 10 -> IDLE next cycle, ready high, valid never asserts; new divu 9/3 then yields 3.
REQ-035 W_ready_i low 5 cycles in DONE -> result and valid held; async rst_n low mid-CALC -> all outputs 0, ready high after release.
